// File: rtl/data_pack_pkg.sv
// Shared definitions for the 16-to-32 sample packer and its matching
// 32-to-16 unpacker in the JESD loopback path.
//   - default sample and packed-word widths
//   - pair-phase encoding used by the packer FSM
//   - PACK_RATIO: samples per packed word, common to packer and unpacker
package data_pack_pkg;

    localparam int DEF_DATA_IN_WIDTH  = 16;
    localparam int DEF_DATA_OUT_WIDTH = 32;
    localparam int PACK_RATIO         = 2;

    // PH_LOW: waiting for the low (first) sample of a pair.
    // PH_HIGH: low sample held, waiting for the high (second) sample.
    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// The head entry is presented combinationally on pop_data while the FIFO is
// non-empty; pop_data reads as zero when empty.
// Ports:
//   clk_out, rst_n  : clock, asynchronous active-low reset
//   push, push_data : write request and data; ignored when full unless a
//                     pop is accepted in the same cycle
//   pop             : consume the head entry; ignored when empty
//   pop_data        : head entry (zero when empty)
//   full, empty     : occupancy flags
//   level           : current occupancy, 0..DEPTH
module sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_out,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // A pop frees the slot the simultaneous push needs, so a full FIFO still
    // accepts a write when the head is consumed in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; the read side is gated by empty,
    // so stale contents are never observable and the array can map to RAM.
    always_ff @(posedge clk_out) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/data_16to32_pack.sv
// Packs a stream of I/Q samples into words of two samples each.
// The first sample of a pair lands in the low half, the second in the high
// half, matching the low-half-first order of the downstream unpacker.
// Ports:
//   clk_out, rst_n         : sample-rate clock, asynchronous active-low reset
//   din_valid              : input sample qualifier
//   din_sync               : marks the low sample of a pair (with din_valid)
//   din_real, din_imag     : I and Q samples
//   dout_ready             : downstream accepts the head word
//   dout_valid             : output FIFO non-empty
//   dout_real, dout_imag   : packed words {second, first}; zero when invalid
//   fifo_level             : output FIFO occupancy
//   overflow               : sticky, a word was dropped on a full FIFO
//   align_err              : sticky, din_sync seen with a half-filled pair
//   clr_status             : synchronous clear of the sticky flags
module data_16to32_pack
    import data_pack_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk_out,
    input  logic                          rst_n,
    input  logic                          din_valid,
    input  logic                          din_sync,
    input  logic [DATA_IN_WIDTH-1:0]      din_real,
    input  logic [DATA_IN_WIDTH-1:0]      din_imag,
    input  logic                          dout_ready,
    output logic                          dout_valid,
    output logic [DATA_OUT_WIDTH-1:0]     dout_real,
    output logic [DATA_OUT_WIDTH-1:0]     dout_imag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          align_err,
    input  logic                          clr_status
);

    if (DATA_OUT_WIDTH != PACK_RATIO * DATA_IN_WIDTH) begin : g_bad_width
        $error("data_16to32_pack: DATA_OUT_WIDTH must be twice DATA_IN_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_16to32_pack: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int FW = 2 * DATA_OUT_WIDTH;

    phase_t                     phase_q;
    phase_t                     phase_d;
    logic [DATA_IN_WIDTH-1:0]   lo_real;
    logic [DATA_IN_WIDTH-1:0]   lo_imag;
    logic                       capture_lo;
    logic                       push;
    logic                       set_align;
    logic                       set_overflow;
    logic [FW-1:0]              push_word;
    logic [FW-1:0]              head_word;
    logic                       fifo_full;
    logic                       fifo_empty;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_LOW;
        end else begin
            phase_q <= phase_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        phase_d    = phase_q;
        capture_lo = 1'b0;
        push       = 1'b0;
        set_align  = 1'b0;
        if (din_valid) begin
            case (phase_q)
                PH_LOW: begin
                    capture_lo = 1'b1;
                    phase_d    = PH_HIGH;
                end
                PH_HIGH: begin
                    if (din_sync) begin
                        // A new pair started early: the held sample is
                        // orphaned, so restart the pair from this sample.
                        set_align  = 1'b1;
                        capture_lo = 1'b1;
                    end else begin
                        push    = 1'b1;
                        phase_d = PH_LOW;
                    end
                end
                default: phase_d = PH_LOW;
            endcase
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            lo_real <= '0;
            lo_imag <= '0;
        end else if (capture_lo) begin
            lo_real <= din_real;
            lo_imag <= din_imag;
        end
    end

    // FIFO entry layout: imag word in the upper half, real word in the lower.
    assign push_word = {din_imag, lo_imag, din_real, lo_real};

    // A full FIFO only drops the word when the head is not consumed this
    // cycle; full implies non-empty, so dout_ready alone decides the pop.
    assign set_overflow = push & fifo_full & ~dout_ready;

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_out   (clk_out),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (dout_ready),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign dout_valid = ~fifo_empty;
    assign dout_real  = head_word[DATA_OUT_WIDTH-1:0];
    assign dout_imag  = head_word[FW-1:DATA_OUT_WIDTH];

    // Set takes priority over clear so an event in the clearing cycle is kept.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (set_overflow) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
            if (set_align) begin
                align_err <= 1'b1;
            end else if (clr_status) begin
                align_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_16to32_pack.sv
// Directed bench for data_16to32_pack with a scoreboard of expected words.
module tb_data_16to32_pack;

    localparam int DEPTH = 4;

    logic        clk_out;
    logic        rst_n;
    logic        din_valid;
    logic        din_sync;
    logic [15:0] din_real;
    logic [15:0] din_imag;
    logic        dout_ready;
    logic        dout_valid;
    logic [31:0] dout_real;
    logic [31:0] dout_imag;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        align_err;
    logic        clr_status;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] sb [$];
    logic        m_high;
    logic [15:0] m_lo_r;
    logic [15:0] m_lo_i;
    logic        m_ovf;
    logic        m_align;

    data_16to32_pack #(
        .DATA_IN_WIDTH  (16),
        .DATA_OUT_WIDTH (32),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_out    (clk_out),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_sync   (din_sync),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout_real  (dout_real),
        .dout_imag  (dout_imag),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .align_err  (align_err),
        .clr_status (clr_status)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_high  = 1'b0;
        m_lo_r  = '0;
        m_lo_i  = '0;
        m_ovf   = 1'b0;
        m_align = 1'b0;
    endtask

    // Compares every visible output against the model.
    task automatic check_state();
        logic [63:0] head;
        head = (sb.size() != 0) ? sb[0] : 64'h0;
        check("dout_valid", 64'(dout_valid), 64'(sb.size() != 0));
        check("fifo_level", 64'(fifo_level), 64'(sb.size()));
        check("head_word", {dout_imag, dout_real}, head);
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("align_err", 64'(align_err), 64'(m_align));
    endtask

    // Advances one clock: model the edge, then sample outputs #1 after it.
    task automatic tick();
        logic        do_pop;
        logic        do_push;
        logic        ovf_set;
        logic        al_set;
        logic [63:0] word;
        logic [63:0] got;
        do_pop  = dout_ready && (sb.size() != 0);
        do_push = 1'b0;
        al_set  = 1'b0;
        ovf_set = 1'b0;
        word    = '0;
        if (do_pop) begin
            got = {dout_imag, dout_real};
            check("pop_word", got, sb.pop_front());
        end
        if (din_valid) begin
            if (!m_high) begin
                m_lo_r = din_real;
                m_lo_i = din_imag;
                m_high = 1'b1;
            end else if (din_sync) begin
                al_set = 1'b1;
                m_lo_r = din_real;
                m_lo_i = din_imag;
            end else begin
                do_push = 1'b1;
                word    = {din_imag, m_lo_i, din_real, m_lo_r};
                m_high  = 1'b0;
            end
        end
        if (do_push) begin
            if (sb.size() < DEPTH) sb.push_back(word);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr_status) m_ovf = 1'b0;
        if (al_set) m_align = 1'b1;
        else if (clr_status) m_align = 1'b0;
        @(posedge clk_out);
        #1;
        check_state();
    endtask

    task automatic sample(input logic [15:0] r, input logic [15:0] i, input logic sync);
        din_valid = 1'b1;
        din_sync  = sync;
        din_real  = r;
        din_imag  = i;
        tick();
        din_valid = 1'b0;
        din_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din_sync  = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_sync   = 1'b0;
        din_real   = '0;
        din_imag   = '0;
        dout_ready = 1'b0;
        clr_status = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_out);
        #1;
        check_state();
        rst_n = 1'b1;
        idle(1);

        // Basic packing with the consumer always ready
        dout_ready = 1'b1;
        sample(16'h1111, 16'h9111, 1'b0);
        sample(16'h2222, 16'h9222, 1'b0);
        sample(16'h3333, 16'h9333, 1'b0);
        sample(16'h4444, 16'h9444, 1'b0);
        idle(3);

        // Gap between the two halves of a pair
        sample(16'hAAAA, 16'h5AAA, 1'b0);
        idle(3);
        sample(16'hBBBB, 16'h5BBB, 1'b0);
        idle(2);

        // Early sync re-anchors the pair and raises align_err
        sample(16'h0001, 16'h8001, 1'b1);
        sample(16'h0002, 16'h8002, 1'b1);
        sample(16'h0003, 16'h8003, 1'b0);
        idle(2);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        idle(1);

        // Backpressure: five words into a four-deep FIFO
        dout_ready = 1'b0;
        for (int k = 0; k < 10; k++)
            sample(16'(16'h1000 + k), 16'(16'h2000 + k), 1'b0);
        idle(1);
        dout_ready = 1'b1;
        idle(6);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        idle(1);

        // Full FIFO accepts a push when the head is popped in the same cycle
        dout_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            sample(16'(16'h3000 + k), 16'(16'h4000 + k), 1'b0);
        sample(16'h3100, 16'h4100, 1'b0);
        dout_ready = 1'b1;
        sample(16'h3101, 16'h4101, 1'b0);
        dout_ready = 1'b0;
        idle(1);
        dout_ready = 1'b1;
        idle(6);

        // Reset in the middle of a pair discards the held half
        sample(16'h7777, 16'h6777, 1'b0);
        rst_n = 1'b0;
        #3;
        model_reset();
        check_state();
        @(posedge clk_out);
        #1;
        rst_n = 1'b1;
        idle(1);
        sample(16'h5555, 16'hD555, 1'b0);
        sample(16'h6666, 16'hD666, 1'b0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_16to32_pack.md
Name: data_16to32_pack

Overview:
- Upstream stage of the JESD loopback 32-to-16 unpacker. Packs a stream of 16-bit I/Q samples into 32-bit I/Q words, two samples per word.
- The first sample of each pair goes to bits [15:0] and the second to bits [31:16]. This matches the low-half-first order the unpacker emits.
- Includes pair-phase alignment, a small FWFT output FIFO with ready backpressure, and sticky status flags for overflow and misalignment.

Parameters:
- DATA_IN_WIDTH, 16: sample width per I or Q rail.
- DATA_OUT_WIDTH, 32: packed word width; must equal 2*DATA_IN_WIDTH, with elaboration error otherwise.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk_out, in, 1: block clock (sample-rate clock).
- rst_n, in, 1: asynchronous, active-low reset.
- din_valid, in, 1: input sample qualifier.
- din_sync, in, 1: marks the first (low) sample of a pair; only meaningful with din_valid.
- din_real, in, DATA_IN_WIDTH: I sample.
- din_imag, in, DATA_IN_WIDTH: Q sample.
- dout_ready, in, 1: downstream accepts the head word.
- dout_valid, out, 1: FIFO non-empty.
- dout_real, out, DATA_OUT_WIDTH: packed I word {second, first}.
- dout_imag, out, DATA_OUT_WIDTH: packed Q word {second, first}.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, out, 1: sticky; a word was dropped because the FIFO was full.
- align_err, out, 1: sticky; din_sync arrived while a pair was half-filled.
- clr_status, in, 1: synchronous clear of the sticky flags.

Behaviour:
- Reset (rst_n low, async): phase=LOW, hold regs=0, FIFO empty, dout_valid=0, dout_real/imag=0, fifo_level=0, overflow=0, align_err=0. Reset mid-pair discards the partial pair.
- Phase FSM, two states LOW and HIGH, advancing only on din_valid=1:
  - LOW: capture din_real/imag into the lo hold registers, then go to HIGH. din_sync is accepted or ignored here; no error.
  - HIGH, din_sync=0: form {din_real, lo_real} and {din_imag, lo_imag}, push to the FIFO, then go to LOW.
  - HIGH, din_sync=1: set align_err, discard the held lo sample, capture the current sample as the new lo, stay in HIGH. No push.
  - din_valid=0: state and hold registers unchanged. Gaps between the two samples of a pair are allowed.
- Without any din_sync, pairing free-runs from reset: the first valid sample after reset is the low half.
- FIFO (FWFT):
  - dout_real/imag present the head entry when dout_valid=1 and are forced to 0 when dout_valid=0.
  - Pop when dout_valid & dout_ready.
  - Latency: a push at clock edge N gives dout_valid=1 after edge N, i.e. visible in cycle N+1 when the FIFO was empty.
- Full FIFO:
  - A push with no pop that cycle drops the word and sets overflow. FIFO contents are unchanged.
  - A push with a pop in the same cycle is accepted; level stays FIFO_DEPTH.
- Empty FIFO: dout_ready is ignored and no pop occurs. A push and a ready in the same cycle do not bypass; the word appears next cycle.
- fifo_level: +1 on push-only, −1 on pop-only, unchanged on both or neither. Pointers wrap modulo FIFO_DEPTH.
- Status flags: clr_status clears overflow and align_err next cycle. If a set event coincides with clr_status, the set wins.
- All arithmetic is unsigned bit concatenation; no sign handling and no rounding.

Decomposition:
- Shared package data_pack_pkg:
  - DATA_IN_WIDTH and DATA_OUT_WIDTH defaults.
  - Phase enum {PH_LOW, PH_HIGH}.
  - Ratio constant PACK_RATIO=2, shared with the unpacker.
- One sub-module: sync_fifo_fwft (parameters WIDTH=2*DATA_OUT_WIDTH, DEPTH). Provides push/pop, full/empty, and level. The top holds the phase FSM, hold registers, and flags.

Test Plan:
- Reset, then valid samples I=0x1111,0x2222,0x3333,0x4444 with ready=1 → words 0x22221111 then 0x44443333. Each dout_valid arrives 1 cycle after the second sample; imag is packed identically.
- Samples 0xAAAA, (valid low for 3 cycles), 0xBBBB → single word 0xBBBBAAAA. No flags set.
- din_sync with 0x0001, then din_sync again with 0x0002, then 0x0003 → align_err=1 and word 0x00030002. clr_status → align_err=0 next cycle.
- ready=0 with 10 consecutive valid samples (5 pairs), FIFO_DEPTH=4 → fifo_level=4 and overflow=1. Fifth word is lost; after ready=1, the first 4 words drain in order.
- Full FIFO with a push and ready=1 in the same cycle → level stays 4, no overflow, and the new word appears last.
- Assert rst_n low after one sample of a pair, then release and send 0x5555,0x6666 → output word 0x66665555, FIFO empty before it.
